mux_nx1_scan: RTL and testbench
===============================

# mux_nx1_scan

Parametrised, registered N:1 channel sampler with a valid/ready output handshake. It replaces the 4:1 combinational select with a clocked block. On a start request it either samples one selected channel (single mode) or sweeps every channel in ascending order (scan mode). Each sample is presented to a downstream consumer, which accepts it with a valid/ready handshake. It sits between the grouped input channels and any sequential consumer that needs stable, tagged samples.

## Interface
Parameters:
- N_CH, 4, number of input channels; a power of two, at least 2.
- W, 1, data width per channel.
- SEL_W, $clog2(N_CH), width of the select and channel tag (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset. It is synchronous and active-low.
- i  in  N_CH*W  packed channels; channel k occupies bits [k*W+W-1 : k*W].
- s  in  SEL_W  channel select for single mode; sampled only on an accepted start.
- mode  in  1  0 = single, 1 = scan; sampled only on an accepted start.
- start  in  1  request a transaction; level, evaluated each cycle.
- out_ready  in  1  consumer accepts F when out_valid=1.
- F  out  W  sampled channel data.
- ch  out  SEL_W  channel index that F was taken from.
- out_valid  out  1  F and ch hold a sample.
- busy  out  1  a transaction is in progress (state != IDLE).
- done  out  1  one-cycle pulse after the last sample of a transaction is accepted.

## Operation
- FSM states: IDLE, HOLD.
- **Reset** (rst_n=0 at the edge):
  - state=IDLE, F=0, ch=0, out_valid=0, busy=0, done=0, mode_q=0.
  - Reset overrides all other inputs.
  - Reset mid-transaction abandons it silently; no done pulse is issued.
- **IDLE, start=1:**
  - Latch mode_q=mode.
  - First channel c0 = s in single mode, 0 in scan mode.
  - On the same edge: F<=i[c0], ch<=c0, out_valid<=1, go to HOLD.
- **IDLE, start=0:** no change. out_valid=0.
- **HOLD, out_ready=0:**
  - F, ch and out_valid hold.
  - i is not re-sampled; input changes do not reach F.
- **HOLD, out_ready=1:**
  - If mode_q=1 and ch != N_CH-1: F<=i[ch+1], ch<=ch+1, stay in HOLD. This allows back-to-back samples.
  - Otherwise: out_valid<=0, done<=1, go to IDLE.
- start is ignored while busy=1. This includes the cycle of the final handshake, so a new transaction needs start high in IDLE.
- ch increments in SEL_W bits. It never wraps, because the last-channel check ends the sweep first.
- Single mode produces exactly 1 handshake. Scan mode produces exactly N_CH handshakes, with ch = 0..N_CH-1 in order.

## Timing
- Start-to-valid latency is 1 cycle: with start high at edge n, out_valid is high after edge n.
- With out_ready held high, a scan completes in N_CH cycles after the first valid, at one sample per cycle.
- done is high for exactly the one cycle following the final accepted handshake. It is 0 in all other cycles.
- Minimum spacing between transactions is 2 cycles, start edge to start edge, when out_ready=1.
- out_valid never drops without a handshake, except under reset.
- F and ch are stable whenever out_valid=1 and out_ready=0.
- busy equals out_valid, and is combinationally derived from state.

## Structure
- Shared package mux_pkg holds:
  - the state encoding constants (IDLE=1'b0, HOLD=1'b1);
  - the mode constants (MODE_SINGLE=0, MODE_SCAN=1).
- One sub-module, mux_nx1: a purely combinational, parametrised N_CH-by-W select (i, sel -> y).
  - It is instantiated once. Its sel is driven by the next-channel value (c0 or ch+1).
- Top level contains the FSM, the output registers and the done register.

## Test plan
Use N_CH=4, W=4, and i={4'hD,4'hC,4'hB,4'hA} (ch0=A) unless stated otherwise.
1. **Reset:** hold rst_n=0 for 2 cycles with start=1 -> F=0, ch=0, out_valid=0, busy=0, done=0. Release with start=0 -> all outputs remain 0.
2. **Single mode:** s=2, mode=0, start pulse, out_ready=1 -> next cycle F=C, ch=2, out_valid=1. The following cycle out_valid=0 and done=1 for one cycle.
3. **Scan, ready held high:** mode=1, start pulse -> F=A,B,C,D on consecutive cycles with ch=0,1,2,3. Then out_valid=0 and done pulses once.
4. **Scan with backpressure:** out_ready=0 for 3 cycles on ch=1, changing i to all 4'hF during the stall -> F stays B and ch stays 1. After release, the next sample is ch=2, F=F.
5. **start while busy:** start held high through the whole scan -> exactly 4 samples. After done, one IDLE cycle, then a new transaction begins.
6. **Reset mid-scan:** assert rst_n=0 at ch=2 -> after that edge out_valid=0, ch=0, F=0, and no done pulse.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared encodings for the registered N:1 channel sampler.
package mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nx1_scan_if.sv
// Channel inputs, start request and valid/ready sample output of mux_nx1_scan.
interface mux_nx1_scan_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 1
);
    localparam int unsigned SEL_W = $clog2(N_CH);

    logic [N_CH*W-1:0] i;
    logic [SEL_W-1:0]  s;
    logic              mode;
    logic              start;
    logic              out_ready;
    logic [W-1:0]      F;
    logic [SEL_W-1:0]  ch;
    logic              out_valid;
    logic              busy;
    logic              done;

    modport master (
        output i, s, mode, start, out_ready,
        input  F, ch, out_valid, busy, done
    );

    modport slave (
        input  i, s, mode, start, out_ready,
        output F, ch, out_valid, busy, done
    );

endinterface

// File: rtl/mux_nx1.sv
// Combinational N_CH-by-W select; channel k sits at bits [k*W +: W].
module mux_nx1 #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 1,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] i,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (sel == SEL_W'(k)) begin
                y = i[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// Registered N:1 sampler: one selected channel or an ascending sweep, each sample
// handed downstream over valid/ready.
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 1
) (
    input logic           clk,
    input logic           rst_n,
    mux_nx1_scan_if.slave bus
);

    localparam int unsigned     SEL_W   = $clog2(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    state_e           state;
    logic             mode_q;
    logic [W-1:0]     f_q;
    logic [SEL_W-1:0] ch_q;
    logic             valid_q;
    logic             done_q;

    logic [SEL_W-1:0] nxt_ch;
    logic [W-1:0]     nxt_f;

    // One shared select: first channel when idle, following channel while holding.
    always_comb begin
        if (state == IDLE) begin
            nxt_ch = (bus.mode == MODE_SINGLE) ? bus.s : '0;
        end else begin
            nxt_ch = ch_q + 1'b1;
        end
    end

    mux_nx1 #(
        .N_CH (N_CH),
        .W    (W)
    ) u_sel (
        .i   (bus.i),
        .sel (nxt_ch),
        .y   (nxt_f)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode_q  <= MODE_SINGLE;
            f_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_q  <= bus.mode;
                        f_q     <= nxt_f;
                        ch_q    <= nxt_ch;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        if (mode_q == MODE_SCAN && ch_q != LAST_CH) begin
                            f_q  <= nxt_f;
                            ch_q <= nxt_ch;
                        end else begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.F         = f_q;
    assign bus.ch        = ch_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state == HOLD);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed and randomized bench for mux_nx1_scan against a queue-based sample model.
module tb_mux_nx1_scan;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 4;
    localparam logic [15:0] I_DEF = {4'hD, 4'hC, 4'hB, 4'hA};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mux_nx1_scan_if #(.N_CH(N_CH), .W(W)) bus ();

    mux_nx1_scan #(
        .N_CH (N_CH),
        .W    (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] chan(input logic [15:0] v, input int k);
        logic [15:0] sh;
        sh = v >> (k * 4);
        return sh[3:0];
    endfunction

    // Model: a transaction is the list of channels still to be delivered.
    int         pend[$];
    logic       m_valid = 1'b0;
    logic [3:0] m_f     = '0;
    int         m_ch    = 0;
    logic       m_done  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            pend.delete();
            m_valid = 1'b0;
            m_f     = '0;
            m_ch    = 0;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_valid) begin
                if (bus.start) begin
                    if (bus.mode) begin
                        for (int k = 0; k < int'(N_CH); k++) pend.push_back(k);
                    end else begin
                        pend.push_back(int'(bus.s));
                    end
                    m_ch    = pend[0];
                    m_f     = chan(bus.i, pend[0]);
                    m_valid = 1'b1;
                end
            end else if (bus.out_ready) begin
                void'(pend.pop_front());
                if (pend.size() > 0) begin
                    m_ch = pend[0];
                    m_f  = chan(bus.i, pend[0]);
                end else begin
                    m_valid = 1'b0;
                    m_done  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_out_valid", 32'(bus.out_valid), 32'(m_valid));
            check("mdl_busy", 32'(bus.busy), 32'(m_valid));
            check("mdl_done", 32'(bus.done), 32'(m_done));
            if (m_valid) begin
                check("mdl_F", 32'(bus.F), 32'(m_f));
                check("mdl_ch", 32'(bus.ch), 32'(m_ch));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic v, input logic [3:0] f,
                              input logic [1:0] c, input logic d);
        check({name, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({name, "_busy"}, 32'(bus.busy), 32'(v));
        check({name, "_done"}, 32'(bus.done), 32'(d));
        if (v) begin
            check({name, "_F"}, 32'(bus.F), 32'(f));
            check({name, "_ch"}, 32'(bus.ch), 32'(c));
        end
    endtask

    initial begin
        bus.i         = I_DEF;
        bus.s         = '0;
        bus.mode      = 1'b0;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset held with start high.
        step();
        chk_en = 1'b1;
        step();
        check("rst_F", 32'(bus.F), 32'h0);
        check("rst_ch", 32'(bus.ch), 32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        step();
        expect_out("rel", 1'b0, 4'h0, 2'd0, 1'b0);
        check("rel_F", 32'(bus.F), 32'h0);

        // Single mode, channel 2.
        bus.s = 2'd2; bus.mode = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        expect_out("single", 1'b1, 4'hC, 2'd2, 1'b0);
        step();
        expect_out("single_end", 1'b0, 4'h0, 2'd0, 1'b1);
        step();
        expect_out("single_idle", 1'b0, 4'h0, 2'd0, 1'b0);

        // Scan with ready high: A,B,C,D then done.
        bus.mode = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_out("scan", 1'b1, chan(I_DEF, k), 2'(k), 1'b0);
            step();
        end
        expect_out("scan_end", 1'b0, 4'h0, 2'd0, 1'b1);
        step();
        expect_out("scan_idle", 1'b0, 4'h0, 2'd0, 1'b0);

        // Scan with a 3-cycle stall on ch1 while inputs change.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        expect_out("bp0", 1'b1, 4'hA, 2'd0, 1'b0);
        step();
        expect_out("bp1", 1'b1, 4'hB, 2'd1, 1'b0);
        bus.out_ready = 1'b0;
        bus.i = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_out("bp_stall", 1'b1, 4'hB, 2'd1, 1'b0);
        end
        bus.out_ready = 1'b1;
        step();
        expect_out("bp2", 1'b1, 4'hF, 2'd2, 1'b0);
        step();
        expect_out("bp3", 1'b1, 4'hF, 2'd3, 1'b0);
        step();
        expect_out("bp_end", 1'b0, 4'h0, 2'd0, 1'b1);
        bus.i = I_DEF;

        // start held high throughout: exactly 4 samples, one idle cycle, then restart.
        bus.start = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            expect_out("hold_start", 1'b1, chan(I_DEF, k), 2'(k), 1'b0);
            step();
        end
        expect_out("hold_done", 1'b0, 4'h0, 2'd0, 1'b1);
        step();
        expect_out("hold_restart", 1'b1, 4'hA, 2'd0, 1'b0);
        bus.start = 1'b0;
        begin
            int guard = 0;
            while (bus.busy && guard < 20) begin
                step();
                guard++;
            end
            check("hold_drain_timeout", 32'(guard < 20), 32'h1);
        end
        step();

        // Reset mid-scan at ch2: no done pulse.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        expect_out("mid_pre", 1'b1, 4'hC, 2'd2, 1'b0);
        rst_n = 1'b0;
        step();
        check("mid_valid", 32'(bus.out_valid), 32'h0);
        check("mid_ch", 32'(bus.ch), 32'h0);
        check("mid_F", 32'(bus.F), 32'h0);
        check("mid_done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;
        step();
        expect_out("mid_after", 1'b0, 4'h0, 2'd0, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            bus.i         = 16'($urandom);
            bus.s         = 2'($urandom_range(0, 3));
            bus.mode      = 1'($urandom_range(0, 1));
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst_n         = ($urandom_range(0, 79) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
